// File: rtl/risc_16_exec_unit.sv
// Five-phase (T1..T5) multi-cycle execution unit for a tiny 16-bit RISC:
// one-hot tick ring, IR, four general registers, operand/result latches, flags.
module risc_16_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] instruction,
  output logic [4:0]  tick_out,
  output logic [15:0] display,
  output logic [1:0]  flags
);

  typedef enum logic [4:0] {
    T1 = 5'b10000,
    T2 = 5'b01000,
    T3 = 5'b00100,
    T4 = 5'b00010,
    T5 = 5'b00001
  } tick_t;

  tick_t       tick_reg, tick_next;
  logic [15:0] ir_reg;
  logic [15:0] op_a_reg, op_b_reg;
  logic [15:0] res_reg;
  logic        carry_reg, zero_reg;
  logic [1:0]  flags_reg;
  logic [15:0] display_reg;
  logic [15:0] rf_reg [4];

  logic [3:0]  opcode;
  logic [1:0]  rd;
  logic [15:0] imm;
  logic [15:0] add_rhs;
  logic [16:0] sum17;
  logic [15:0] alu_result;
  logic        alu_carry;
  logic        writes;
  logic        is_out;
  logic        unused_ir;

  assign opcode    = ir_reg[15:12];
  assign rd        = ir_reg[1:0];
  assign imm       = {12'h000, ir_reg[11:8]};
  assign unused_ir = ^ir_reg[7:2];

  // Tick ring: anything that is not a legal one-hot phase falls back to T1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_reg <= T1;
    else     tick_reg <= tick_next;
  end

  always_comb begin
    tick_next = T1;
    case (tick_reg)
      T1:      tick_next = enable ? T2 : T1;
      T2:      tick_next = enable ? T3 : T2;
      T3:      tick_next = enable ? T4 : T3;
      T4:      tick_next = enable ? T5 : T4;
      T5:      tick_next = enable ? T1 : T5;
      default: tick_next = T1;
    endcase
  end

  always_comb begin
    add_rhs    = (opcode == 4'hA) ? op_b_reg : imm;
    sum17      = {1'b0, op_a_reg} + {1'b0, add_rhs};
    alu_result = 16'h0000;
    alu_carry  = 1'b0;
    case (opcode)
      4'h1: alu_result = imm;
      4'h2, 4'hA: begin
        alu_result = sum17[15:0];
        alu_carry  = sum17[16];
      end
      4'h3: begin
        alu_result = op_a_reg - imm;
        alu_carry  = (op_a_reg < imm);
      end
      4'h4: alu_result = op_a_reg & imm;
      4'h5: alu_result = op_a_reg | imm;
      4'h6: alu_result = op_a_reg ^ imm;
      4'h7: begin
        alu_result = {op_a_reg[14:0], 1'b0};
        alu_carry  = op_a_reg[15];
      end
      4'h8: begin
        alu_result = {1'b0, op_a_reg[15:1]};
        alu_carry  = op_a_reg[0];
      end
      4'h9: alu_result = op_b_reg;
      default: begin
        alu_result = 16'h0000;
        alu_carry  = 1'b0;
      end
    endcase
    writes = (opcode >= 4'h1) && (opcode <= 4'hA);
    is_out = (opcode == 4'hB);
  end

  // Only T5 touches architectural state, so a reset before then leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_reg      <= 16'h0000;
      op_a_reg    <= 16'h0000;
      op_b_reg    <= 16'h0000;
      res_reg     <= 16'h0000;
      carry_reg   <= 1'b0;
      zero_reg    <= 1'b0;
      flags_reg   <= 2'b00;
      display_reg <= 16'h0000;
      for (int i = 0; i < 4; i++) rf_reg[i] <= 16'h0000;
    end else if (enable) begin
      case (tick_reg)
        T2: ir_reg <= instruction;
        T3: begin
          op_a_reg <= rf_reg[rd];
          op_b_reg <= rf_reg[ir_reg[9:8]];
        end
        T4: begin
          res_reg   <= alu_result;
          carry_reg <= alu_carry;
          zero_reg  <= (alu_result == 16'h0000);
        end
        T5: begin
          if (writes) begin
            rf_reg[rd]  <= res_reg;
            display_reg <= res_reg;
            flags_reg   <= {carry_reg, zero_reg};
          end else if (is_out) begin
            display_reg <= op_a_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign tick_out = tick_reg;
  assign display  = display_reg;
  assign flags    = flags_reg;

endmodule

// File: tb/tb_risc_16_exec_unit.sv
// Directed bench for risc_16_exec_unit: phase walk, ALU ops, freeze and reset cases.
module tb_risc_16_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] instruction;
  logic [4:0]  tick_out;
  logic [15:0] display;
  logic [1:0]  flags;

  int tests_run = 0;
  int tests_failed = 0;

  risc_16_exec_unit dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .instruction(instruction),
    .tick_out(tick_out),
    .display(display),
    .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction is presented during T1 and held through the full 5-clock cycle.
  task automatic run_instr(input logic [15:0] instr);
    instruction = instr;
    repeat (5) tick();
    $display("[TB] instr %h -> display %h flags %b", instr, display, flags);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    instruction = 16'h0000;
    #2;
    tests_run++; if (tick_out !== 5'b10000) begin tests_failed++; $display("FAIL reset_tick got %b want %b", tick_out, 5'b10000); end
    tests_run++; if (display !== 16'h0000) begin tests_failed++; $display("FAIL reset_display got %h want %h", display, 16'h0000); end
    tests_run++; if (flags !== 2'b00) begin tests_failed++; $display("FAIL reset_flags got %b want %b", flags, 2'b00); end
    tick();
    tick();
    tests_run++; if (tick_out !== 5'b10000) begin tests_failed++; $display("FAIL reset_dominates_enable got %b want %b", tick_out, 5'b10000); end
    rst = 1'b0;
    $display("[TB] reset released");
  endtask

  task automatic test_ldi();
    logic [4:0] walk [5] = '{5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b10000};
    instruction = 16'h1502;
    tests_run++; if (tick_out !== 5'b10000) begin tests_failed++; $display("FAIL ldi_start_tick got %b want %b", tick_out, 5'b10000); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests_run++; if (tick_out !== walk[i]) begin tests_failed++; $display("FAIL ldi_walk_%0d got %b want %b", i, tick_out, walk[i]); end
    end
    tests_run++; if (display !== 16'h0005) begin tests_failed++; $display("FAIL ldi_display got %h want %h", display, 16'h0005); end
    tests_run++; if (flags !== 2'b00) begin tests_failed++; $display("FAIL ldi_flags got %b want %b", flags, 2'b00); end
    run_instr(16'hB002);
    tests_run++; if (display !== 16'h0005) begin tests_failed++; $display("FAIL ldi_out_r2 got %h want %h", display, 16'h0005); end
  endtask

  task automatic test_shl();
    run_instr(16'h1F01);
    tests_run++; if (display !== 16'h000F) begin tests_failed++; $display("FAIL shl_ldi got %h want %h", display, 16'h000F); end
    repeat (12) run_instr(16'h7001);
    tests_run++; if (display !== 16'hF000) begin tests_failed++; $display("FAIL shl12_display got %h want %h", display, 16'hF000); end
    tests_run++; if (flags !== 2'b00) begin tests_failed++; $display("FAIL shl12_flags got %b want %b", flags, 2'b00); end
    run_instr(16'h7001);
    tests_run++; if (display !== 16'hE000) begin tests_failed++; $display("FAIL shl13_display got %h want %h", display, 16'hE000); end
    tests_run++; if (flags !== 2'b10) begin tests_failed++; $display("FAIL shl13_flags got %b want %b", flags, 2'b10); end
  endtask

  task automatic test_subi_addi();
    run_instr(16'h3100);
    tests_run++; if (display !== 16'hFFFF) begin tests_failed++; $display("FAIL subi_display got %h want %h", display, 16'hFFFF); end
    tests_run++; if (flags !== 2'b10) begin tests_failed++; $display("FAIL subi_flags got %b want %b", flags, 2'b10); end
    run_instr(16'h2100);
    tests_run++; if (display !== 16'h0000) begin tests_failed++; $display("FAIL addi_wrap_display got %h want %h", display, 16'h0000); end
    tests_run++; if (flags !== 2'b11) begin tests_failed++; $display("FAIL addi_wrap_flags got %b want %b", flags, 2'b11); end
  endtask

  task automatic test_freeze();
    run_instr(16'h1303);
    tests_run++; if (display !== 16'h0003) begin tests_failed++; $display("FAIL freeze_ldi_r3 got %h want %h", display, 16'h0003); end
    instruction = 16'hA103;
    tick();
    tick();
    tests_run++; if (tick_out !== 5'b00100) begin tests_failed++; $display("FAIL freeze_at_t3 got %b want %b", tick_out, 5'b00100); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++; if (tick_out !== 5'b00100) begin tests_failed++; $display("FAIL freeze_tick_%0d got %b want %b", i, tick_out, 5'b00100); end
      tests_run++; if (display !== 16'h0003) begin tests_failed++; $display("FAIL freeze_display_%0d got %h want %h", i, display, 16'h0003); end
    end
    enable = 1'b1;
    tick();
    tests_run++; if (tick_out !== 5'b00010) begin tests_failed++; $display("FAIL freeze_resume_t4 got %b want %b", tick_out, 5'b00010); end
    tick();
    tick();
    $display("[TB] instr a103 (frozen 3 clocks) -> display %h flags %b", display, flags);
    tests_run++; if (display !== 16'hE003) begin tests_failed++; $display("FAIL freeze_add_display got %h want %h", display, 16'hE003); end
    tests_run++; if (flags !== 2'b00) begin tests_failed++; $display("FAIL freeze_add_flags got %b want %b", flags, 2'b00); end
    run_instr(16'hB001);
    tests_run++; if (display !== 16'hE000) begin tests_failed++; $display("FAIL freeze_out_r1 got %h want %h", display, 16'hE000); end
    run_instr(16'hB003);
    tests_run++; if (display !== 16'hE003) begin tests_failed++; $display("FAIL freeze_out_r3 got %h want %h", display, 16'hE003); end
  endtask

  task automatic test_async_reset();
    instruction = 16'h1700;
    repeat (3) tick();
    tests_run++; if (tick_out !== 5'b00010) begin tests_failed++; $display("FAIL areset_at_t4 got %b want %b", tick_out, 5'b00010); end
    #2 rst = 1'b1;
    #1;
    tests_run++; if (tick_out !== 5'b10000) begin tests_failed++; $display("FAIL areset_tick got %b want %b", tick_out, 5'b10000); end
    tests_run++; if (display !== 16'h0000) begin tests_failed++; $display("FAIL areset_display got %h want %h", display, 16'h0000); end
    #1 rst = 1'b0;
    tick();
    tests_run++; if (tick_out !== 5'b01000) begin tests_failed++; $display("FAIL areset_first_advance got %b want %b", tick_out, 5'b01000); end
    instruction = 16'h2100;
    repeat (4) tick();
    $display("[TB] instr 2100 after reset -> display %h flags %b", display, flags);
    tests_run++; if (display !== 16'h0001) begin tests_failed++; $display("FAIL areset_r0_clear got %h want %h", display, 16'h0001); end
    tests_run++; if (flags !== 2'b00) begin tests_failed++; $display("FAIL areset_flags got %b want %b", flags, 2'b00); end
  endtask

  task automatic test_ignore_and_out();
    run_instr(16'h1902);
    run_instr(16'h3101);
    tests_run++; if (flags !== 2'b10) begin tests_failed++; $display("FAIL ign_setup_flags got %b want %b", flags, 2'b10); end
    instruction = 16'hB002;
    tick();
    tick();
    instruction = 16'h1F02;
    tick();
    instruction = 16'h2F02;
    tick();
    instruction = 16'h3F02;
    tick();
    $display("[TB] instr b002 (input churned T3-T5) -> display %h flags %b", display, flags);
    tests_run++; if (display !== 16'h0009) begin tests_failed++; $display("FAIL ign_out_display got %h want %h", display, 16'h0009); end
    tests_run++; if (flags !== 2'b10) begin tests_failed++; $display("FAIL ign_out_flags got %b want %b", flags, 2'b10); end
    run_instr(16'hB001);
    tests_run++; if (display !== 16'hFFFF) begin tests_failed++; $display("FAIL ign_out_r1 got %h want %h", display, 16'hFFFF); end
    run_instr(16'hB002);
    tests_run++; if (display !== 16'h0009) begin tests_failed++; $display("FAIL ign_r2_kept got %h want %h", display, 16'h0009); end
  endtask

  // Starts from R0=1, R1=FFFF, R2=9, R3=0.
  task automatic test_alu_ops();
    logic [15:0] v_instr [10] = '{16'h4501, 16'h5A03, 16'h6A03, 16'hC5FF, 16'h8001,
                                  16'h9203, 16'hA303, 16'h0F02, 16'h1F01, 16'h3F01};
    logic [15:0] v_disp  [10] = '{16'h0005, 16'h000A, 16'h0000, 16'h0000, 16'h0002,
                                  16'h0009, 16'h0012, 16'h0012, 16'h000F, 16'h0000};
    logic [1:0]  v_flags [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                                  2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 10; i++) begin
      run_instr(v_instr[i]);
      tests_run++; if (display !== v_disp[i]) begin tests_failed++; $display("FAIL alu_%h_display got %h want %h", v_instr[i], display, v_disp[i]); end
      tests_run++; if (flags !== v_flags[i]) begin tests_failed++; $display("FAIL alu_%h_flags got %b want %b", v_instr[i], flags, v_flags[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_shl();
    test_subi_addi();
    test_freeze();
    test_async_reset();
    test_ignore_and_out();
    test_alu_ops();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
